bgn_layer_sequencer: RTL and testbench
======================================

Name: bgn_layer_sequencer

Overview:
- Top-level control FSM for the bgn_inference accelerator.
- Accepts one inference request on an ap_ctrl_chain-style handshake.
- Launches each pipelined layer loop module in order (LAYER1 then LAYER2 by default) over its ap_start/ap_ready/ap_done handshake, then reports completion.
- Also provides per-inference latency and inference-count profiling registers, and a sticky protocol-error flag for verification.

Parameters:
- N_LAYERS, 2, number of sequenced layer modules (≥1); index 0 runs first.
- CNT_W, 32, width of the cycle and inference counters.
- WDOG_LIMIT, 4096, per-layer cycle limit (used only with the optional feature).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ap_start  in  1  request one inference.
- ap_ready  out  1  request accepted this cycle.
- ap_done  out  1  inference complete; held until ap_continue.
- ap_idle  out  1  sequencer idle.
- ap_continue  in  1  consumer acknowledges ap_done.
- layer_start  out  N_LAYERS  one-hot ap_start to the layer modules.
- layer_ready  in  N_LAYERS  ap_ready from the layer modules.
- layer_done  in  N_LAYERS  ap_done pulses from the layer modules.
- cur_layer  out  $clog2(N_LAYERS)+1  active layer index.
- total_cycles  out  CNT_W  busy cycles of the last completed inference.
- infer_count  out  CNT_W  completed inferences.
- protocol_err  out  1  sticky handshake violation.
- timeout  out  1  sticky watchdog abort (see Optional Feature).

Behaviour:
- Reset (async, immediate):
  - State IDLE, idx=0.
  - ap_ready=0, ap_done=0, ap_idle=1, layer_start=0, cur_layer=0.
  - total_cycles=0, infer_count=0, protocol_err=0, timeout=0.
  - Reset mid-inference drops layer_start the same instant; no completion is reported.
- Outputs:
  - ap_idle = (state==IDLE).
  - ap_ready = (state==IDLE && ap_start), combinational.
  - layer_start = onehot(idx) when state==LAUNCH, else 0. It is a decode of registered state only; there is no input-to-output combinational path.
  - cur_layer = idx.
- IDLE:
  - If ap_start: go to LAUNCH with idx=0 and clear the busy counter.
- LAUNCH:
  - layer_start[idx] is held until layer_ready[idx] is sampled high.
  - ready && !done: go to RUN.
  - ready && done (zero-latency layer), or done alone: go to ADVANCE behaviour directly (done implies ready).
- RUN:
  - Wait for layer_done[idx]; on it, perform ADVANCE.
- ADVANCE (transition only, not a state):
  - If idx==N_LAYERS-1: go to DONE.
  - Otherwise: idx+1, go to LAUNCH.
- DONE:
  - ap_done=1 and total_cycles is latched on entry.
  - Held until ap_continue is sampled high (ap_continue may already be high on entry, giving a 1-cycle ap_done).
  - On ap_continue: infer_count+1 (saturating), go to IDLE.
  - ap_start is ignored in DONE. Back-to-back inferences therefore see exactly one IDLE cycle between them.
- Busy counter:
  - Increments every cycle in LAUNCH or RUN; saturates at all-ones.
  - For a layer with ready on its first start cycle and done D cycles later, the layer contributes D+1 cycles.
- protocol_err is set (sticky until reset) when any of the following occurs:
  - layer_ready[j] or layer_done[j] is asserted while j != idx or state is not LAUNCH/RUN;
  - more than one bit of layer_done is asserted in one cycle.
- The offending pulses are otherwise ignored; they never advance the FSM.

Optional Feature:
- Macro: BGN_SEQ_WATCHDOG_EN.
- Defined:
  - A per-layer counter resets on each LAUNCH entry and counts LAUNCH/RUN cycles.
  - On reaching WDOG_LIMIT without layer_done[idx]: timeout is set (sticky), layer_start goes low, and the FSM enters DONE (abort, ap_done raised normally).
  - total_cycles is latched as usual; infer_count still increments on ap_continue.
- Undefined:
  - The counter logic is removed and timeout is tied to 0; the port list is unchanged.

Test Plan:
- Nominal run:
  - Stimulus: reset, then ap_start=1 for 1 cycle; layer0 ready at its first start cycle, done 5 cycles later; layer1 ready at its first start cycle, done 3 cycles later; ap_continue=1.
  - Required response: ap_ready pulses once; layer_start goes 01 then 10; ap_done high 1 cycle; total_cycles=10; infer_count=1; protocol_err=0.
- Delayed acknowledge:
  - Stimulus: as the nominal run, but layer0 ready delayed 4 cycles and ap_continue held low 6 cycles after ap_done.
  - Required response: layer_start[0] stays high 5 cycles; ap_done stays high 7 cycles; total_cycles=14; the ap_start pulse issued during DONE is not accepted.
- Back-to-back:
  - Stimulus: ap_start held high with 3 back-to-back inferences.
  - Required response: exactly one IDLE cycle between ap_done and the next ap_ready; infer_count=3.
- Zero-latency layer and error detection:
  - Stimulus: layer0 done asserted in the same cycle as ready; layer1 done asserted while idx=0.
  - Required response: the sequencer moves to layer1 with no RUN cycle for layer0; protocol_err=1 and remains 1 until reset.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously mid-clock while in RUN of layer1.
  - Required response: layer_start=0, ap_idle=1, idx=0 and counters=0 immediately; the next ap_start runs a clean inference.
- Watchdog (BGN_SEQ_WATCHDOG_EN, WDOG_LIMIT=16):
  - Stimulus: layer0 never asserts done.
  - Required response: timeout=1 after 16 busy cycles; ap_done raised; total_cycles=16.
  - Without the macro, the same stimulus hangs in RUN with timeout=0.

Source files
------------

// File: rtl/bgn_layer_sequencer.sv
// bgn_layer_sequencer: top-level control FSM for the bgn_inference accelerator.
// Accepts one inference on an ap_ctrl_chain handshake and launches each layer
// loop module in order. It also keeps latency and inference-count profiling
// registers and a sticky protocol-error flag.
// Optional feature: define BGN_SEQ_WATCHDOG_EN to enable the per-layer watchdog
// abort. With the macro undefined, timeout is tied to 0.
module bgn_layer_sequencer #(
  parameter int unsigned N_LAYERS   = 2,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned WDOG_LIMIT = 4096
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ap_start,
  output logic                       ap_ready,
  output logic                       ap_done,
  output logic                       ap_idle,
  input  logic                       ap_continue,
  output logic [N_LAYERS-1:0]        layer_start,
  input  logic [N_LAYERS-1:0]        layer_ready,
  input  logic [N_LAYERS-1:0]        layer_done,
  output logic [$clog2(N_LAYERS):0]  cur_layer,
  output logic [CNT_W-1:0]           total_cycles,
  output logic [CNT_W-1:0]           infer_count,
  output logic                       protocol_err,
  output logic                       timeout
);

  localparam int unsigned IDX_W = $clog2(N_LAYERS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LAYERS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                state, state_d;
  logic [IDX_W-1:0]      idx, idx_d;
  logic [CNT_W-1:0]      busy_cnt, busy_inc;
  logic [N_LAYERS-1:0]   idx_onehot, active_mask;
  logic                  busy, sel_ready, sel_done;
  logic                  start_accept, enter_done;
  logic                  stray_pulse, multi_done;
  logic                  wdog_expire;

  // Layer select and handshake qualification
  assign idx_onehot  = N_LAYERS'(1) << idx;
  assign busy        = (state == S_LAUNCH) || (state == S_RUN);
  assign active_mask = busy ? idx_onehot : '0;
  assign sel_ready   = |(layer_ready & idx_onehot);
  assign sel_done    = |(layer_done & idx_onehot);
  assign stray_pulse = |((layer_ready | layer_done) & ~active_mask);
  assign multi_done  = |(layer_done & (layer_done - N_LAYERS'(1)));
  assign busy_inc    = (&busy_cnt) ? busy_cnt : busy_cnt + CNT_W'(1);

  // Outputs are pure decodes of registered state (ap_ready also gates ap_start)
  assign ap_idle     = (state == S_IDLE);
  assign ap_ready    = (state == S_IDLE) && ap_start;
  assign ap_done     = (state == S_DONE);
  assign layer_start = (state == S_LAUNCH) ? idx_onehot : '0;
  assign cur_layer   = idx;

  // State and layer-index registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  end

  // Next-state logic; a layer's done (with or without ready) advances directly
  always_comb begin
    state_d      = state;
    idx_d        = idx;
    start_accept = 1'b0;
    enter_done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (ap_start) begin
          state_d      = S_LAUNCH;
          idx_d        = '0;
          start_accept = 1'b1;
        end
      end
      S_LAUNCH, S_RUN: begin
        if (sel_done) begin
          if (idx == LAST_IDX) begin
            state_d    = S_DONE;
            enter_done = 1'b1;
          end else begin
            state_d = S_LAUNCH;
            idx_d   = idx + IDX_W'(1);
          end
        end else if (wdog_expire) begin
          state_d    = S_DONE;
          enter_done = 1'b1;
        end else if ((state == S_LAUNCH) && sel_ready) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (ap_continue) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Busy-cycle profiling, inference counter and sticky protocol error
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_cnt     <= '0;
      total_cycles <= '0;
      infer_count  <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (start_accept) begin
        busy_cnt <= '0;
      end else if (busy) begin
        busy_cnt <= busy_inc;
      end
      // busy_inc includes the cycle that takes us into DONE
      if (enter_done) begin
        total_cycles <= busy_inc;
      end
      if ((state == S_DONE) && ap_continue && !(&infer_count)) begin
        infer_count <= infer_count + CNT_W'(1);
      end
      if (stray_pulse || multi_done) begin
        protocol_err <= 1'b1;
      end
    end
  end

`ifdef BGN_SEQ_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_LIMIT + 1);

  logic [WD_W-1:0] wdog_cnt;

  assign wdog_expire = busy && !sel_done && (wdog_cnt == WD_W'(WDOG_LIMIT - 1));

  // Per-layer cycle counter, restarted whenever a layer is launched
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdog_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (start_accept || (busy && sel_done)) begin
        wdog_cnt <= '0;
      end else if (busy) begin
        wdog_cnt <= wdog_cnt + WD_W'(1);
      end
      if (wdog_expire) begin
        timeout <= 1'b1;
      end
    end
  end
`else
  logic unused_wdog_limit;

  // Watchdog removed: never aborts
  assign wdog_expire       = 1'b0;
  assign timeout           = 1'b0;
  assign unused_wdog_limit = ^WDOG_LIMIT;
`endif

endmodule

// File: tb/tb_bgn_layer_sequencer.sv
// Self-checking bench for bgn_layer_sequencer (2 layers, watchdog limit 16).
// The expected timeline of each inference comes from per-layer ready/done delays.
module tb_bgn_layer_sequencer;

  localparam int unsigned NL = 2;
  localparam int unsigned CW = 32;
  localparam int unsigned WL = 16;

  logic           clock;
  logic           reset;
  logic           ap_start;
  logic           ap_ready;
  logic           ap_done;
  logic           ap_idle;
  logic           ap_continue;
  logic [NL-1:0]  layer_start;
  logic [NL-1:0]  layer_ready;
  logic [NL-1:0]  layer_done;
  logic [1:0]     cur_layer;
  logic [CW-1:0]  total_cycles;
  logic [CW-1:0]  infer_count;
  logic           protocol_err;
  logic           timeout;

  int n_tests;
  int n_fail;
  int exp_count;
  bit exp_perr;
  bit hold_start;

  bgn_layer_sequencer #(.N_LAYERS(NL), .CNT_W(CW), .WDOG_LIMIT(WL)) dut (
    .clock(clock), .reset(reset),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
    .ap_continue(ap_continue),
    .layer_start(layer_start), .layer_ready(layer_ready), .layer_done(layer_done),
    .cur_layer(cur_layer), .total_cycles(total_cycles), .infer_count(infer_count),
    .protocol_err(protocol_err), .timeout(timeout)
  );

  always #5 clock = ~clock;

  function automatic logic [NL-1:0] oh(input int i);
    oh = NL'(1) << i;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // IDLE cycle that issues the request
  task automatic start_req(input bit hold);
    @(negedge clock);
    ap_start    = 1'b1;
    ap_continue = 1'b0;
    layer_ready = '0;
    layer_done  = '0;
    #1;
    chk("idle_before_start", 64'(ap_idle), 64'(1));
    chk("ap_ready_accept", 64'(ap_ready), 64'(1));
    chk("ap_done_in_idle", 64'(ap_done), 64'(0));
    chk("layer_start_idle", 64'(layer_start), 64'(0));
    chk("infer_count_idle", 64'(infer_count), 64'(exp_count));
    chk("protocol_err_idle", 64'(protocol_err), 64'(exp_perr));
    hold_start = hold;
  endtask

  // Layer i: ready after r extra cycles, done d cycles after ready
  task automatic run_layer(input int i, input int r, input int d, input logic [NL-1:0] inj);
    for (int c = 0; c <= r; c++) begin
      @(negedge clock);
      ap_start    = hold_start;
      layer_ready = '0;
      layer_done  = '0;
      if (c == r) begin
        layer_ready = oh(i);
        if (d == 0) layer_done = oh(i);
        layer_done = layer_done | inj;
        if (inj != '0) exp_perr = 1'b1;
      end
      #1;
      chk("layer_start_launch", 64'(layer_start), 64'(oh(i)));
      chk("cur_layer_launch", 64'(cur_layer), 64'(i));
      chk("ap_ready_busy", 64'(ap_ready), 64'(0));
      chk("ap_idle_busy", 64'(ap_idle), 64'(0));
    end
    for (int c = 1; c <= d; c++) begin
      @(negedge clock);
      ap_start    = hold_start;
      layer_ready = '0;
      layer_done  = (c == d) ? oh(i) : '0;
      #1;
      chk("layer_start_run", 64'(layer_start), 64'(0));
      chk("cur_layer_run", 64'(cur_layer), 64'(i));
      chk("ap_done_run", 64'(ap_done), 64'(0));
    end
  endtask

  // DONE phase: ap_continue after cdly cycles; optional ap_start poke must be ignored
  task automatic finish_req(input int cdly, input int exp_total, input bit poke);
    for (int c = 0; c <= cdly; c++) begin
      @(negedge clock);
      layer_ready = '0;
      layer_done  = '0;
      ap_start    = (poke && c == 0 && cdly > 0) ? 1'b1 : hold_start;
      ap_continue = (c == cdly);
      #1;
      chk("ap_done_held", 64'(ap_done), 64'(1));
      chk("ap_ready_in_done", 64'(ap_ready), 64'(0));
      chk("layer_start_done", 64'(layer_start), 64'(0));
      chk("infer_count_done", 64'(infer_count), 64'(exp_count));
      if (c == 0) chk("total_cycles", 64'(total_cycles), 64'(exp_total));
    end
    exp_count++;
  endtask

  task automatic run_inference(input int r0, input int d0, input int r1, input int d1,
                               input int cdly, input bit hold, input bit poke,
                               input logic [NL-1:0] inj);
    start_req(hold);
    run_layer(0, r0, d0, inj);
    run_layer(1, r1, d1, '0);
    finish_req(cdly, (r0 + d0 + 1) + (r1 + d1 + 1), poke);
  endtask

  task automatic idle_check();
    @(negedge clock);
    ap_start    = 1'b0;
    ap_continue = 1'b0;
    layer_ready = '0;
    layer_done  = '0;
    #1;
    chk("idle_after", 64'(ap_idle), 64'(1));
    chk("ap_done_after", 64'(ap_done), 64'(0));
    chk("infer_count_after", 64'(infer_count), 64'(exp_count));
    chk("protocol_err_after", 64'(protocol_err), 64'(exp_perr));
  endtask

  initial begin
    #200000;
    $display("FAIL tb_timeout: observed no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    n_tests = 0; n_fail = 0; exp_count = 0; exp_perr = 1'b0; hold_start = 1'b0;
    clock = 1'b0; reset = 1'b1;
    ap_start = 1'b0; ap_continue = 1'b0; layer_ready = '0; layer_done = '0;

    // Reset values
    #1;
    chk("rst_ap_idle", 64'(ap_idle), 64'(1));
    chk("rst_ap_ready", 64'(ap_ready), 64'(0));
    chk("rst_ap_done", 64'(ap_done), 64'(0));
    chk("rst_layer_start", 64'(layer_start), 64'(0));
    chk("rst_cur_layer", 64'(cur_layer), 64'(0));
    chk("rst_total", 64'(total_cycles), 64'(0));
    chk("rst_count", 64'(infer_count), 64'(0));
    chk("rst_perr", 64'(protocol_err), 64'(0));
    chk("rst_timeout", 64'(timeout), 64'(0));
    @(negedge clock);
    reset = 1'b0;

    // Nominal: total 6 + 4 = 10
    run_inference(0, 5, 0, 3, 0, 1'b0, 1'b0, '0);
    idle_check();

    // Delayed ready and continue, with an ap_start poke during DONE
    run_inference(4, 5, 0, 3, 6, 1'b0, 1'b1, '0);
    idle_check();

    // Back-to-back with ap_start held high
    run_inference(0, 2, 1, 1, 0, 1'b1, 1'b0, '0);
    run_inference(1, 0, 0, 2, 1, 1'b1, 1'b0, '0);
    run_inference(0, 1, 2, 0, 0, 1'b1, 1'b0, '0);
    idle_check();

    // Zero-latency layer0 plus a stray layer1 done while idx=0
    run_inference(0, 0, 1, 2, 0, 1'b0, 1'b0, oh(1));
    idle_check();

    // Randomised inferences; protocol_err must stay sticky
    for (int k = 0; k < 8; k++) begin
      run_inference(int'($urandom_range(3, 0)), int'($urandom_range(6, 0)),
                    int'($urandom_range(3, 0)), int'($urandom_range(6, 0)),
                    int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                    1'($urandom_range(1, 0)), '0);
    end
    idle_check();

    // Asynchronous reset while layer1 is in RUN
    start_req(1'b0);
    run_layer(0, 1, 2, '0);
    @(negedge clock);
    ap_start = 1'b0; layer_ready = oh(1); layer_done = '0;
    #1;
    chk("mid_launch_l1", 64'(layer_start), 64'(oh(1)));
    @(negedge clock);
    layer_ready = '0;
    #1;
    chk("mid_run_l1_start", 64'(layer_start), 64'(0));
    chk("mid_run_l1_idx", 64'(cur_layer), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("arst_layer_start", 64'(layer_start), 64'(0));
    chk("arst_ap_idle", 64'(ap_idle), 64'(1));
    chk("arst_cur_layer", 64'(cur_layer), 64'(0));
    chk("arst_total", 64'(total_cycles), 64'(0));
    chk("arst_count", 64'(infer_count), 64'(0));
    chk("arst_perr", 64'(protocol_err), 64'(0));
    chk("arst_ap_done", 64'(ap_done), 64'(0));
    exp_count = 0;
    exp_perr  = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    run_inference(1, 2, 0, 1, 1, 1'b0, 1'b0, '0);
    idle_check();

    // Layer0 never finishes
    start_req(1'b0);
    @(negedge clock);
    ap_start = 1'b0; layer_ready = oh(0);
    #1;
    chk("wd_launch", 64'(layer_start), 64'(oh(0)));
    for (int c = 2; c <= int'(WL); c++) begin
      @(negedge clock);
      layer_ready = '0;
      #1;
      chk("wd_pre_timeout", 64'(timeout), 64'(0));
      chk("wd_pre_done", 64'(ap_done), 64'(0));
    end
    @(negedge clock);
    #1;
`ifdef BGN_SEQ_WATCHDOG_EN
    chk("wd_ap_done", 64'(ap_done), 64'(1));
    chk("wd_timeout", 64'(timeout), 64'(1));
    chk("wd_total", 64'(total_cycles), 64'(WL));
    chk("wd_layer_start", 64'(layer_start), 64'(0));
    ap_continue = 1'b1;
    exp_count++;
    idle_check();
    chk("wd_timeout_sticky", 64'(timeout), 64'(1));
`else
    for (int c = 0; c < 24; c++) begin
      @(negedge clock);
      #1;
      chk("nowd_ap_done", 64'(ap_done), 64'(0));
      chk("nowd_timeout", 64'(timeout), 64'(0));
      chk("nowd_busy", 64'(ap_idle), 64'(0));
    end
    chk("nowd_cur_layer", 64'(cur_layer), 64'(0));
`endif
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
